ahb_burst_master: RTL and testbench

- AHB-Lite master that executes one INCR burst per command from the core_set address generator (address, beat count, size, read/write).
- Drives the AHB bus.
- Returns read beats to the rotate line buffer.
- Pulls write beats from the rotate line buffer.
- Sits directly downstream of core_set, between the rotate core and system memory.

---
 rtl/ahb_burst_master.sv | 161 ++++++++++++++++
 tb/tb_ahb_burst_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
// AHB-Lite master that runs one INCR burst per core_set command, returning read beats
// and pulling write beats through simple valid/ack side channels.
module ahb_burst_master #(
   parameter int P_BOUNDARY_BITS = 10
) (
   input  logic        I_AM_HCLK,
   input  logic        I_AM_HRESET,
   input  logic        I_AM_CMD_VALID,
   output logic        O_AM_CMD_READY,
   input  logic [31:0] I_AM_ADDR,
   input  logic [4:0]  I_AM_COUNT,
   input  logic [2:0]  I_AM_SIZE,
   input  logic        I_AM_WRITE,
   input  logic [31:0] I_AM_WDATA,
   input  logic        I_AM_WVALID,
   output logic        O_AM_WACK,
   output logic [31:0] O_AM_RDATA,
   output logic        O_AM_RVALID,
   output logic        O_AM_DONE,
   output logic        O_AM_ERR,
   output logic        O_AM_BUSY,
   output logic [31:0] O_AM_HADDR,
   output logic [1:0]  O_AM_HTRANS,
   output logic        O_AM_HWRITE,
   output logic [2:0]  O_AM_HSIZE,
   output logic [2:0]  O_AM_HBURST,
   output logic [31:0] O_AM_HWDATA,
   input  logic [31:0] I_AM_HRDATA,
   input  logic        I_AM_HREADY,
   input  logic        I_AM_HRESP
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LAST, S_DONE, S_ERR} state_t;

   state_t      state, state_nxt;
   logic [31:0] haddr, prev_addr, hwdata, rdata;
   logic [4:0]  cnt, addr_cnt;
   logic [2:0]  size;
   logic        wr, dphase, err_flag, rvalid;

   logic        cmd_fire, err_hit, accept, last_beat, rd_ok, err_set, burst_on;
   logic [1:0]  trans;
   logic [31:0] step;

   assign cmd_fire  = I_AM_CMD_VALID && O_AM_CMD_READY;
   assign step      = 32'd1 << size;
   assign last_beat = (addr_cnt == cnt - 5'd1);
   // An ERROR response only matters while one of our data phases is outstanding.
   assign err_hit   = dphase && I_AM_HRESP && ((state == S_ADDR) || (state == S_LAST));
   assign accept    = (state == S_ADDR) && trans[1] && I_AM_HREADY;
   assign rd_ok     = dphase && I_AM_HREADY && !I_AM_HRESP && !wr &&
                      ((state == S_ADDR) || (state == S_LAST));

   always_comb begin
      state_nxt = state;
      trans     = TR_IDLE;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_fire)
               state_nxt = (I_AM_COUNT == 5'd0) ? S_DONE : S_ADDR;
         end
         S_ADDR: begin
            if (err_hit) begin
               err_set   = 1'b1;
               state_nxt = I_AM_HREADY ? S_DONE : S_ERR;
            end else begin
               if (!wr || I_AM_WVALID)
                  trans = ((addr_cnt == 5'd0) ||
                           (haddr[31:P_BOUNDARY_BITS] != prev_addr[31:P_BOUNDARY_BITS]))
                          ? TR_NONSEQ : TR_SEQ;
               else
                  trans = (addr_cnt == 5'd0) ? TR_IDLE : TR_BUSY;
               if (I_AM_HREADY && trans[1] && last_beat)
                  state_nxt = S_LAST;
            end
         end
         S_LAST: begin
            if (err_hit) begin
               err_set   = 1'b1;
               state_nxt = I_AM_HREADY ? S_DONE : S_ERR;
            end else if (I_AM_HREADY) begin
               state_nxt = S_DONE;
            end
         end
         S_ERR: begin
            if (I_AM_HREADY)
               state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge I_AM_HCLK or posedge I_AM_HRESET) begin
      if (I_AM_HRESET) begin
         state     <= S_IDLE;
         haddr     <= 32'd0;
         prev_addr <= 32'd0;
         cnt       <= 5'd0;
         addr_cnt  <= 5'd0;
         size      <= 3'd0;
         wr        <= 1'b0;
         dphase    <= 1'b0;
         err_flag  <= 1'b0;
         hwdata    <= 32'd0;
         rdata     <= 32'd0;
         rvalid    <= 1'b0;
      end else begin
         state  <= state_nxt;
         rvalid <= rd_ok;
         if (rd_ok)
            rdata <= I_AM_HRDATA;
         if (cmd_fire) begin
            haddr    <= I_AM_ADDR;
            cnt      <= I_AM_COUNT;
            addr_cnt <= 5'd0;
            size     <= (I_AM_SIZE > 3'd2) ? 3'd2 : I_AM_SIZE;
            wr       <= I_AM_WRITE;
            err_flag <= 1'b0;
            dphase   <= 1'b0;
         end else begin
            if (err_set)
               err_flag <= 1'b1;
            if (accept) begin
               addr_cnt  <= addr_cnt + 5'd1;
               prev_addr <= haddr;
               // HADDR stays on the final beat so it never points past the burst.
               if (!last_beat)
                  haddr <= haddr + step;
               if (wr)
                  hwdata <= I_AM_WDATA;
               dphase <= 1'b1;
            end else if (I_AM_HREADY) begin
               dphase <= 1'b0;
            end
         end
      end
   end

   assign burst_on       = (state != S_IDLE) && (cnt != 5'd0);
   assign O_AM_CMD_READY = (state == S_IDLE) && !I_AM_HRESET;
   assign O_AM_WACK      = accept && wr;
   assign O_AM_RDATA     = rdata;
   assign O_AM_RVALID    = rvalid;
   assign O_AM_DONE      = (state == S_DONE);
   assign O_AM_ERR       = (state == S_DONE) && err_flag;
   assign O_AM_BUSY      = (state != S_IDLE);
   assign O_AM_HADDR     = haddr;
   assign O_AM_HTRANS    = trans;
   assign O_AM_HWRITE    = burst_on && wr;
   assign O_AM_HSIZE     = burst_on ? size : 3'd0;
   assign O_AM_HBURST    = burst_on ? 3'b001 : 3'b000;
   assign O_AM_HWDATA    = hwdata;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: a small AHB slave plus a transaction-level
// model of the expected address phases, read beats, write data and completion.
`timescale 1ns/1ps
module tb_ahb_burst_master;

   localparam int B = 10;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [31:0] cmd_addr = 32'd0;
   logic [4:0]  cmd_count = 5'd0;
   logic [2:0]  cmd_size = 3'd0;
   logic        cmd_write = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic        wvalid = 1'b0, wack;
   logic [31:0] rdata;
   logic        rvalid, done, err, busy;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [31:0] hrdata = 32'd0;
   logic        hready = 1'b1, hresp = 1'b0;

   ahb_burst_master #(.P_BOUNDARY_BITS(B)) dut (
      .I_AM_HCLK(clk), .I_AM_HRESET(rst),
      .I_AM_CMD_VALID(cmd_valid), .O_AM_CMD_READY(cmd_ready),
      .I_AM_ADDR(cmd_addr), .I_AM_COUNT(cmd_count), .I_AM_SIZE(cmd_size),
      .I_AM_WRITE(cmd_write), .I_AM_WDATA(wdata), .I_AM_WVALID(wvalid),
      .O_AM_WACK(wack), .O_AM_RDATA(rdata), .O_AM_RVALID(rvalid),
      .O_AM_DONE(done), .O_AM_ERR(err), .O_AM_BUSY(busy),
      .O_AM_HADDR(haddr), .O_AM_HTRANS(htrans), .O_AM_HWRITE(hwrite),
      .O_AM_HSIZE(hsize), .O_AM_HBURST(hburst), .O_AM_HWDATA(hwdata),
      .I_AM_HRDATA(hrdata), .I_AM_HREADY(hready), .I_AM_HRESP(hresp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0, total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] wdata_of(input int k);
      return 32'hD000_0000 + 32'(k);
   endfunction

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  trans;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] rexp_q[$];
   logic        cur_write = 1'b0, exp_err = 1'b0, done_err_val = 1'b0;
   logic [2:0]  cur_size = 3'd0;
   logic [31:0] first_rdata = 32'd0;
   int done_cnt = 0, done_cyc = 0, last_acc_cyc = 0, first_act_cyc = -1, acc_cmd_cyc = 0;
   int rv_cnt = 0, wack_cnt = 0, busyt_cnt = 0, nonseq_cnt = 0, act_cnt = 0;
   int hold_cnt = 0, err_idle_cnt = 0, cmd_acc_cnt = 0;

   // slave / write-source state
   logic        dp_busy = 1'b0, dp_wr = 1'b0, w_active = 1'b0;
   logic [31:0] dp_addr = 32'd0;
   int dp_beat = 0, beat_idx = 0, stall_beat = -1, stall_len = 0, stall_left = 0;
   int err_beat = -1, err_left = 0, widx = 0, wgap = 0, w_count = 0, wgap_len = 0;

   // Expected burst: beat k at start + k*step; NONSEQ on the first beat or a 1 KB crossing.
   task automatic load_model(input logic [31:0] a, input int n, input int sz);
      beat_t e;
      logic [31:0] prev;
      int st;
      st = 1 << ((sz > 2) ? 2 : sz);
      exp_q.delete();
      rexp_q.delete();
      prev = a;
      for (int k = 0; k < n; k++) begin
         e.addr  = a + 32'(k * st);
         e.trans = (k == 0 || (e.addr >> B) != (prev >> B)) ? 2'b10 : 2'b11;
         prev    = e.addr;
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
         if (cmd_ready) begin
            check("idle_htrans", 32'(htrans), 32'd0);
            check("idle_hburst", 32'(hburst), 32'd0);
            check("idle_hwrite", 32'(hwrite), 32'd0);
         end
         if (cmd_valid && cmd_ready) begin
            cmd_acc_cnt++;
            acc_cmd_cyc = cyc;
         end
         check("wack_rule", 32'(wack), 32'(hwrite && wvalid && htrans[1] && hready));
         if (hresp && !hready) begin
            check("err_first_idle", 32'(htrans), 32'd0);
            err_idle_cnt++;
            exp_q.delete();
            exp_err = 1'b1;
         end
         if (htrans[1]) begin
            act_cnt++;
            check("hwrite", 32'(hwrite), 32'(cur_write));
            check("hsize", 32'(hsize), 32'(cur_size));
            check("hburst", 32'(hburst), 32'd1);
            if (first_act_cyc < 0) first_act_cyc = cyc;
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL extra_addr_phase: haddr 0x%0h, none expected", haddr);
            end else begin
               check("haddr", haddr, exp_q[0].addr);
               check("htrans", 32'(htrans), 32'(exp_q[0].trans));
               if (hready) begin
                  if (htrans == 2'b10) nonseq_cnt++;
                  last_acc_cyc = cyc;
                  void'(exp_q.pop_front());
               end else begin
                  hold_cnt++;
               end
            end
         end
         if (htrans == 2'b01) begin
            busyt_cnt++;
            if (exp_q.size() > 0) check("busy_haddr", haddr, exp_q[0].addr);
         end
         if (wack) wack_cnt++;
         if (rvalid) begin
            rv_cnt++;
            if (rv_cnt == 1) first_rdata = rdata;
            if (rexp_q.size() == 0) begin
               total++;
               $display("FAIL extra_rvalid: rdata 0x%0h, none expected", rdata);
            end else begin
               check("rdata", rdata, rexp_q.pop_front());
            end
         end
         if (dp_busy && hready && !hresp) begin
            if (dp_wr) check("hwdata", hwdata, wdata_of(dp_beat));
            else rexp_q.push_back(rd_of(dp_addr));
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err_val = err;
            check("done_err", 32'(err), 32'(exp_err));
            check("beats_left_at_done", 32'(exp_q.size()), 32'd0);
         end else begin
            check("err_without_done", 32'(err), 32'd0);
         end
      end
   end

   // One bus cycle: sample at the falling edge, then drive the slave/source after the rising edge.
   task automatic step();
      logic acc, w, wk;
      logic [31:0] a;
      @(negedge clk);
      acc = htrans[1] && hready;
      a   = haddr;
      w   = hwrite;
      wk  = wack;
      @(posedge clk);
      #1;
      if (dp_busy && hready) dp_busy = 1'b0;
      if (acc) begin
         dp_busy    = 1'b1;
         dp_addr    = a;
         dp_wr      = w;
         dp_beat    = beat_idx;
         beat_idx++;
         stall_left = (dp_beat == stall_beat) ? stall_len : 0;
         err_left   = (dp_beat == err_beat) ? 2 : 0;
      end
      if (dp_busy && err_left == 2) begin
         hready = 1'b0; hresp = 1'b1; err_left = 1;
      end else if (dp_busy && err_left == 1) begin
         hready = 1'b1; hresp = 1'b1; err_left = 0;
      end else if (dp_busy && stall_left > 0) begin
         hready = 1'b0; hresp = 1'b0; stall_left--;
      end else begin
         hready = 1'b1; hresp = 1'b0;
      end
      hrdata = dp_busy ? rd_of(dp_addr) : 32'd0;
      if (wk) begin
         widx++;
         if (widx == 2) wgap = wgap_len;
      end
      if (wgap > 0) begin
         wvalid = 1'b0;
         wgap--;
      end else begin
         wvalid = w_active && (widx < w_count);
      end
      wdata = wdata_of(widx);
   endtask

   task automatic send_cmd(input logic [31:0] a, input int n, input int sz, input logic w);
      load_model(a, n, sz);
      cur_write = w;
      cur_size  = 3'((sz > 2) ? 2 : sz);
      exp_err   = 1'b0;
      done_cnt = 0; rv_cnt = 0; wack_cnt = 0; busyt_cnt = 0; nonseq_cnt = 0; act_cnt = 0;
      hold_cnt = 0; err_idle_cnt = 0; cmd_acc_cnt = 0; first_act_cyc = -1; done_err_val = 1'b0;
      beat_idx  = 0;
      cmd_valid = 1'b1; cmd_addr = a; cmd_count = 5'(n); cmd_size = 3'(sz); cmd_write = w;
      w_active  = w; w_count = n; widx = 0; wgap = 0;
      wvalid    = w && (n > 0);
      wdata     = wdata_of(0);
      step();
      cmd_valid = 1'b0;
      check("cmd_accepted", 32'(cmd_acc_cnt), 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done_cnt == 0 && k < budget) begin
         step();
         k++;
      end
      if (done_cnt == 0) begin
         total++;
         $display("FAIL done_timeout: no DONE within %0d cycles", budget);
      end
      w_active = 1'b0;
      wvalid   = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_htrans", 32'(htrans), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_haddr", haddr, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("ready_after_reset", 32'(cmd_ready), 32'd1);

      // plain 6-beat read
      send_cmd(32'h100, 6, 2, 1'b0);
      wait_done(50);
      check("t1_rvalid_count", 32'(rv_cnt), 32'd6);
      check("t1_addr_phases", 32'(act_cnt), 32'd6);
      check("t1_nonseq_count", 32'(nonseq_cnt), 32'd1);
      check("t1_first_nonseq_lat", 32'(first_act_cyc - acc_cmd_cyc), 32'd1);
      check("t1_done_after_last", 32'(done_cyc - last_acc_cyc), 32'd2);
      check("t1_done_latency", 32'(done_cyc - acc_cmd_cyc), 32'd8);
      check("t1_first_rdata", first_rdata, 32'h5A5A_0100);

      // same read, 2 wait states on beat 2's data phase
      stall_beat = 2; stall_len = 2;
      send_cmd(32'h100, 6, 2, 1'b0);
      wait_done(50);
      stall_beat = -1;
      check("t2_rvalid_count", 32'(rv_cnt), 32'd6);
      check("t2_held_cycles", 32'(hold_cnt), 32'd2);
      check("t2_done_latency", 32'(done_cyc - acc_cmd_cyc), 32'd10);

      // write with a 3-cycle WVALID gap after beat 1; SIZE 3 clamps to word
      wgap_len = 3;
      send_cmd(32'h200, 6, 3, 1'b1);
      wait_done(50);
      wgap_len = 0;
      check("t3_wack_count", 32'(wack_cnt), 32'd6);
      check("t3_busy_cycles", 32'(busyt_cnt), 32'd3);
      check("t3_addr_phases", 32'(act_cnt), 32'd6);
      check("t3_done_latency", 32'(done_cyc - acc_cmd_cyc), 32'd11);

      // read crossing the 1 KB boundary at 0x400
      send_cmd(32'h3F8, 6, 2, 1'b0);
      wait_done(50);
      check("t4_nonseq_count", 32'(nonseq_cnt), 32'd2);
      check("t4_rvalid_count", 32'(rv_cnt), 32'd6);
      check("t4_done_latency", 32'(done_cyc - acc_cmd_cyc), 32'd8);

      // ERROR response on beat 3
      err_beat = 3;
      send_cmd(32'h100, 6, 2, 1'b0);
      wait_done(50);
      err_beat = -1;
      check("t5_rvalid_count", 32'(rv_cnt), 32'd3);
      check("t5_err_idle_seen", 32'(err_idle_cnt), 32'd1);
      check("t5_done_err", 32'(done_err_val), 32'd1);
      check("t5_done_latency", 32'(done_cyc - acc_cmd_cyc), 32'd7);
      @(negedge clk);
      check("t5_ready_next", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;

      // zero-count command
      send_cmd(32'h40, 0, 2, 1'b0);
      wait_done(10);
      check("t6_done_latency", 32'(done_cyc - acc_cmd_cyc), 32'd1);
      check("t6_addr_phases", 32'(act_cnt), 32'd0);
      check("t6_done_err", 32'(done_err_val), 32'd0);

      // asynchronous reset in the middle of a read burst
      send_cmd(32'h100, 6, 2, 1'b0);
      step();
      step();
      #2 rst = 1'b1;
      #1;
      check("t7_htrans", 32'(htrans), 32'd0);
      check("t7_haddr", haddr, 32'd0);
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_hburst", 32'(hburst), 32'd0);
      check("t7_rdata", rdata, 32'd0);
      check("t7_hwdata", hwdata, 32'd0);
      check("t7_ready", 32'(cmd_ready), 32'd0);
      exp_q.delete();
      rexp_q.delete();
      dp_busy = 1'b0; err_left = 0; stall_left = 0;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("t7_ready_after", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      step();
      step();
      check("t7_no_done", 32'(done_cnt), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
